// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Used by alu_arbiter, alu_arb_rr2 and their benches.
package alu_arb_pkg;

  localparam int unsigned SELOP_W = 3;
  localparam int unsigned SHAMT_W = 2;
  localparam int unsigned FLAG_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bit positions inside rsp_flags = {C,N,P,Z}
  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_P = 1;
  localparam int unsigned FLG_Z = 0;

  localparam logic [SELOP_W-1:0] OP_ADD = 3'd0;
  localparam logic [SELOP_W-1:0] OP_SUB = 3'd1;
  localparam logic [SELOP_W-1:0] OP_AND = 3'd2;
  localparam logic [SELOP_W-1:0] OP_OR  = 3'd3;
  localparam logic [SELOP_W-1:0] OP_XOR = 3'd4;
  localparam logic [SELOP_W-1:0] OP_NOT = 3'd5;
  localparam logic [SELOP_W-1:0] OP_SHL = 3'd6;
  localparam logic [SELOP_W-1:0] OP_SHR = 3'd7;

  typedef struct packed {
    logic [SELOP_W-1:0] selop;
    logic [SHAMT_W-1:0] shamt;
  } alu_op_t;

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-way grant logic: round-robin on a last_grant register, or fixed
// priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_rr2 (
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       i_accept,
`endif
  input  logic [1:0] i_req,
  output logic       o_gnt_id_c,
  output logic       o_gnt_vld_c
);

  assign o_gnt_vld_c = |i_req;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign o_gnt_id_c = ~i_req[0];
`else
  logic r_last;

  // Reset to 1 so requester 0 wins the first contended round
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_gnt_id_c;
    end
  end

  assign o_gnt_id_c = (&i_req) ? ~r_last : i_req[1];
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters with an
// IDLE->EXEC->RESP sequencer. Macro ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [MAX_WIDTH-1:0] req0_a,
  input  logic [MAX_WIDTH-1:0] req0_b,
  input  logic [SELOP_W-1:0]   req0_selop,
  input  logic [SHAMT_W-1:0]   req0_shamt,
  input  logic                 req0_setf,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [MAX_WIDTH-1:0] req1_a,
  input  logic [MAX_WIDTH-1:0] req1_b,
  input  logic [SELOP_W-1:0]   req1_selop,
  input  logic [SHAMT_W-1:0]   req1_shamt,
  input  logic                 req1_setf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [MAX_WIDTH-1:0] rsp_data,
  output logic [FLAG_W-1:0]    rsp_flags,
  output logic [MAX_WIDTH-1:0] alu_busA,
  output logic [MAX_WIDTH-1:0] alu_busB,
  output logic [SELOP_W-1:0]   alu_selop,
  output logic [SHAMT_W-1:0]   alu_shamt,
  output logic                 alu_enaf,
  input  logic [MAX_WIDTH-1:0] alu_busC,
  input  logic                 alu_C,
  input  logic                 alu_N,
  input  logic                 alu_P,
  input  logic                 alu_Z
);

  state_t               r_state;
  logic [MAX_WIDTH-1:0] r_a;
  logic [MAX_WIDTH-1:0] r_b;
  alu_op_t              r_op;
  logic                 r_id;
  logic                 r_enaf;
  logic                 r_rsp_valid;
  logic [MAX_WIDTH-1:0] r_rsp_data;

  logic                 w_idle;
  logic                 w_gnt_id;
  logic                 w_gnt_vld;
  logic                 w_accept;
  logic [MAX_WIDTH-1:0] w_a;
  logic [MAX_WIDTH-1:0] w_b;
  alu_op_t              w_op;
  logic                 w_setf;

  // Ready is suppressed while reset is asserted even though state reads IDLE
  assign w_idle   = rst && (r_state == ST_IDLE);
  assign w_accept = w_idle && w_gnt_vld;

  alu_arb_rr2 u_rr2 (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk         (clk),
    .rst         (rst),
    .i_accept    (w_accept),
`endif
    .i_req       ({req1_valid, req0_valid}),
    .o_gnt_id_c  (w_gnt_id),
    .o_gnt_vld_c (w_gnt_vld)
  );

  assign req0_ready = w_accept && !w_gnt_id;
  assign req1_ready = w_accept && w_gnt_id;

  assign w_a    = w_gnt_id ? req1_a : req0_a;
  assign w_b    = w_gnt_id ? req1_b : req0_b;
  assign w_op   = w_gnt_id ? alu_op_t'{selop: req1_selop, shamt: req1_shamt}
                           : alu_op_t'{selop: req0_selop, shamt: req0_shamt};
  assign w_setf = w_gnt_id ? req1_setf : req0_setf;

  // Sequencer; operand registers drive the ALU directly and hold between ops
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_id        <= 1'b0;
      r_enaf      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_id    <= w_gnt_id;
            r_enaf  <= w_setf;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= alu_busC;
          r_enaf      <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_busA  = r_a;
  assign alu_busB  = r_b;
  assign alu_selop = r_op.selop;
  assign alu_shamt = r_op.shamt;
  assign alu_enaf  = r_enaf;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;

  // Flags come live from the ALU flag register; they only move while enaf=1
  assign rsp_flags[FLG_C] = alu_C;
  assign rsp_flags[FLG_N] = alu_N;
  assign rsp_flags[FLG_P] = alu_P;
  assign rsp_flags[FLG_Z] = alu_Z;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance (8-bit, flag register with enaf, shift unit) between two requesters.
- Each requester uses a valid/ready request channel.
- The block runs a 3-state sequencer: it grants one requester, drives the ALU from registered operands, captures busC, then returns data, flags and requester id on one shared valid/ready response channel.
- It sits between the core's issue logic and the ALU datapath.

Parameters:
- MAX_WIDTH, 8, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 handshake accepted
- req0_a  in  MAX_WIDTH  operand A
- req0_b  in  MAX_WIDTH  operand B
- req0_selop  in  3  ALU operation
- req0_shamt  in  2  shift amount
- req0_setf  in  1  update ALU flags for this op
- req1_valid, req1_ready, req1_a, req1_b, req1_selop, req1_shamt, req1_setf: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  MAX_WIDTH  captured busC
- rsp_flags  out  4  {C,N,P,Z}
- alu_busA, alu_busB  out  MAX_WIDTH  to ALU
- alu_selop  out  3
- alu_shamt  out  2
- alu_enaf  out  1
- alu_busC  in  MAX_WIDTH
- alu_C, alu_N, alu_P, alu_Z  in  1  ALU flag register outputs

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - Operand/op registers, rsp_data, rsp_id = 0.
  - rsp_valid=0, req*_ready=0, alu_enaf=0.
  - The ALU flag register is reset by the same rst net at top level.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Arbitration is round-robin.
  - If both valid, the requester != last_grant wins.
  - If one valid, it wins.
  - reqN_ready=1 combinationally for the winner only, and only in IDLE.
  - On handshake: latch a/b/selop/shamt/setf and id, set last_grant=id, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_busA/B/selop/shamt driven from the latched registers.
  - alu_enaf = latched setf.
  - At the clock edge: rsp_data <= alu_busC, ALU flags update if enaf; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id stable.
  - rsp_flags = live alu_{C,N,P,Z}, stable because alu_enaf=0 outside EXEC.
  - rsp_valid held until rsp_ready=1, then go to IDLE.
  - rsp_ready with rsp_valid=0 is ignored.
- alu_enaf is 0 in every state except EXEC.
- ALU drive registers hold their last values outside EXEC (no toggling).
- Latency:
  - Request handshake at cycle t; rsp_valid at t+2 (rsp_ready tied high).
  - Peak throughput: 1 op per 3 cycles.
- Back-pressure: while RESP stalls, both ready=0; requests wait. Valid must stay asserted with payload stable until ready (protocol rule; not checked by the block).
- setf=0: flags from the previous op are preserved and returned in rsp_flags.
- Reset mid-operation: the operation is dropped, no response is produced, state=IDLE next cycle.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins when both are valid; last_grant is unused (removed).
- Undefined: round-robin as above.

Decomposition:
- Package alu_arb_pkg holds:
  - state encoding (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2);
  - flag bit indices (FLG_C=3, FLG_N=2, FLG_P=1, FLG_Z=0);
  - selop constants mirroring processing_unit (OP_ADD etc.) for benches.
- One natural sub-module: alu_arb_rr2, the 2-way round-robin grant logic (last_grant register plus combinational grant). The macro selects its fixed-priority variant.
- The ALU instance lives at the parent level, not inside the arbiter.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both valid -> rsp_valid=0, both ready=0, alu_enaf=0. After release, req0 is granted first (ready0=1 in the first IDLE cycle).
- Single op with rsp_ready=1: req0 a=8'hF0, b=8'h20, OP_ADD, shamt=0, setf=1 -> rsp_valid at t+2, rsp_data=8'h10, rsp_id=0, rsp_flags C=1, Z=0. alu_enaf high exactly one cycle.
- Contention: both valid continuously, 4 ops -> grant order 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- Flag preservation: op1 a=8'h01, b=8'hFF, OP_ADD, setf=1 gives result 8'h00 with Z=1. Then op2 a=8'h03, b=8'h04, OP_ADD, setf=0 -> rsp_flags still report Z=1, rsp_data=8'h07.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/data/id/flags stable. req1_valid pending with ready1=0 throughout; granted on the first IDLE cycle after acceptance.
- Reset mid-op: rst=0 during EXEC -> no response, next accepted request completes normally with correct rsp_id.
